imem_pipe: RTL and testbench
============================

# imem_pipe

Parametrised, pipelined instruction memory for the fetch stage: a synchronous-read word memory with a configurable read latency, a request/response valid handshake, stall and flush control from the pipeline, and fault reporting for misaligned or out-of-range fetches. It replaces the combinational, fixed-size instruction ROM. It adds a program-load write port, so the bench or a boot loader can fill memory at run time instead of relying only on the simulation-time file preload.

## Interface
Parameters:
- DATA_WIDTH, default 32: instruction word width; must be 32 (byte-addressed, 4-byte words).
- DEPTH_WORDS, default 1024: number of words; power of two, 16..65536.
- READ_LATENCY, default 1: cycles from accepted request to response; legal range 1..4.
- INIT_FILE, default "": hex file loaded with $readmemh at time zero when non-empty.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request.
- req_addr  in  32  byte address of the fetch.
- stall  in  1  freeze the pipeline; holds the response and all in-flight requests.
- flush  in  1  discard all in-flight requests.
- rsp_valid  out  1  response valid.
- rsp_data  out  DATA_WIDTH  instruction word; 0 when rsp_fault=1.
- rsp_addr  out  32  byte address that produced this response.
- rsp_fault  out  1  request was misaligned or out of range.
- ld_en  in  1  program-load write enable.
- ld_addr  in  32  byte address for the load write.
- ld_data  in  DATA_WIDTH  word to write.

## Operation
- Word index: IW = $clog2(DEPTH_WORDS); index = addr[IW+1:2].
- A request is accepted when req_valid=1 and stall=0, or when flush=1. flush overrides stall for the incoming request (redirect fetch).
- Fault classification is done at acceptance:
  - misaligned: addr[1:0] != 0.
  - out of range: addr[31:IW+2] != 0.
  - A faulting request still flows through the pipeline. Its response has rsp_fault=1 and rsp_data=0. It performs no array read.
- Pipeline is READ_LATENCY stages. Each stage holds {valid, addr, fault}. Stage 1 is the array read register; later stages are plain delay registers.
- stall=1 and flush=0: every stage, the outputs, and the array read register hold their values. A held valid response stays presented for as long as stall is high.
- flush=1: every in-flight stage valid is cleared on that edge. A request presented in the same cycle is accepted into stage 1. So with flush asserted and the redirect request presented together, the next response (after READ_LATENCY cycles) is the redirect target.
- Load port:
  - ld_en=1 writes ld_data to index(ld_addr) on the edge.
  - Ignored if ld_addr is misaligned or out of range.
  - Not affected by stall or flush.
- Read/write collision on the same index in the same cycle is read-before-write: the response carries the old word.
- Memory contents are not reset. Uninitialised words read as X in simulation.

## Timing
- Reset (rst=0, asynchronous): every stage valid=0; rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_fault=0. Reset mid-operation drops all in-flight requests immediately. A load write on the reset edge is not performed.
- Latency: a request accepted at edge N is presented on rsp_* after edge N+READ_LATENCY-1 and is valid during the following cycle. This assumes no stall cycles; each stall cycle adds one cycle.
- Throughput: one request per cycle with stall=0. No backpressure signal is provided; the producer must honour stall itself.
- rsp_valid is 1 only in cycles carrying a response. rsp_data, rsp_addr and rsp_fault hold their last values when rsp_valid=0.
- Simultaneous events on one edge are resolved in this order:
  - rst beats everything.
  - flush beats stall.
  - ld_en is independent of both.
- Address wrap: 0xFFFFFFFC is out of range for every legal DEPTH_WORDS and returns a fault; no index wrap-around is ever performed.

## Test plan
- Back-to-back fetch: preload word[i]=0x1000_0000+i, READ_LATENCY=2, requests 0x0,0x4,0x8 on consecutive cycles -> rsp_valid on cycles 2,3,4 with data 0x10000000, 0x10000001, 0x10000002 and matching rsp_addr.
- Stall: stall=1 for 3 cycles while 2 requests are in flight -> response frozen (rsp_valid, rsp_data unchanged) for 3 cycles, then both responses delivered in order with none lost or duplicated.
- Flush with redirect: in-flight requests to 0x10 and 0x14, then flush=1 with req_addr=0x40 -> no responses for 0x10 or 0x14; next response has rsp_addr=0x40. Repeat with stall=1 during the flush -> same result.
- Faults: req_addr=0x6 -> rsp_fault=1, rsp_data=0. req_addr=DEPTH_WORDS*4 -> rsp_fault=1. req_addr=0xFFFFFFFC -> rsp_fault=1.
- Load port: ld_en writes 0xDEADBEEF to 0x20 while a read of 0x20 is accepted in the same cycle -> that response returns the old word; a read one cycle later returns 0xDEADBEEF. ld_addr=0x22 -> memory unchanged.
- Async reset: drop rst mid-stream between clock edges -> rsp_valid=0 and all outputs 0 immediately. After release, the first response is the first post-reset request.

Source files
------------

// File: rtl/imem_pipe.sv
// imem_pipe: synchronous-read instruction memory with a READ_LATENCY-deep
// response pipeline, stall/flush control, fetch fault reporting and a
// run-time program-load write port.
module imem_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [31:0]           rsp_addr,
  output logic                  rsp_fault,
  input  logic                  ld_en,
  input  logic [31:0]           ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int L  = READ_LATENCY;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Stage k payload; stage 1 doubles as the array read register, stage L
  // drives the response outputs directly.
  logic [L:1]                 vld_pipe;
  logic [L:1][31:0]           addr_pipe;
  logic [L:1]                 flt_pipe;
  logic [L:1][DATA_WIDTH-1:0] dat_pipe;

  logic          advance;
  logic          accept;
  logic          req_fault;
  logic          ld_fault;
  logic [IW-1:0] req_idx;
  logic [IW-1:0] ld_idx;

  // Misaligned, or any address bit above the word index set.
  function automatic logic is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (IW + 2)) != 32'd0);
  endfunction

  // flush forces the pipe to move even under stall (redirect fetch).
  assign advance   = flush || !stall;
  assign accept    = req_valid && advance;
  assign req_fault = is_fault(req_addr);
  assign ld_fault  = is_fault(ld_addr);
  assign req_idx   = req_addr[IW+1:2];
  assign ld_idx    = ld_addr[IW+1:2];

  // Program-load write; blocked while reset is asserted, contents never reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst && ld_en && !ld_fault)
      mem[ld_idx] <= ld_data;
  end

  // Pipeline shift. Payloads only move with a valid entry so the outputs
  // keep their last response while rsp_valid is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
      flt_pipe  <= '0;
      dat_pipe  <= '0;
    end else if (advance) begin
      vld_pipe[1] <= accept;
      if (accept) begin
        addr_pipe[1] <= req_addr;
        flt_pipe[1]  <= req_fault;
        // faulting fetches skip the array; old word on same-index load
        dat_pipe[1]  <= req_fault ? '0 : mem[req_idx];
      end
      for (int k = 2; k <= L; k++) begin
        vld_pipe[k] <= flush ? 1'b0 : vld_pipe[k-1];
        if (!flush && vld_pipe[k-1]) begin
          addr_pipe[k] <= addr_pipe[k-1];
          flt_pipe[k]  <= flt_pipe[k-1];
          dat_pipe[k]  <= dat_pipe[k-1];
        end
      end
    end
  end

  assign rsp_valid = vld_pipe[L];
  assign rsp_addr  = addr_pipe[L];
  assign rsp_fault = flt_pipe[L];
  assign rsp_data  = dat_pipe[L];

endmodule

// File: tb/tb_imem_pipe.sv
// tb_imem_pipe: directed fetch/stall/flush/fault/load/reset vectors, with a
// queue-based response model checked on every falling edge.
module tb_imem_pipe;

  localparam int DEPTH = 64;
  localparam int L     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        stall;
  logic        flush;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [31:0] rsp_addr;
  logic        rsp_fault;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  int n_chk  = 0;
  int n_fail = 0;

  imem_pipe #(
    .DATA_WIDTH  (32),
    .DEPTH_WORDS (DEPTH),
    .READ_LATENCY(L),
    .INIT_FILE   ("")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .stall    (stall),
    .flush    (flush),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_addr (rsp_addr),
    .rsp_fault(rsp_fault),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
    int          rem;   // advancing edges left before it is presented
  } ent_t;

  ent_t        q[$];
  logic [31:0] mm [DEPTH];
  logic        ex_v = 1'b0;
  logic [31:0] ex_a = '0;
  logic [31:0] ex_d = '0;
  logic        ex_f = 1'b0;

  function automatic logic bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  always @(negedge rst) begin
    q.delete();
    ex_v = 1'b0; ex_a = '0; ex_d = '0; ex_f = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      if (flush || !stall) begin
        if (flush) q.delete();
        else if (q.size() > 0 && q[0].rem == 0) void'(q.pop_front());
        foreach (q[i]) q[i].rem = q[i].rem - 1;
        if (req_valid) begin
          ent_t e;
          e.addr  = req_addr;
          e.fault = bad_addr(req_addr);
          e.data  = e.fault ? 32'd0 : mm[req_addr / 4];
          e.rem   = L - 1;
          q.push_back(e);
        end
      end
      if (ld_en && !bad_addr(ld_addr)) mm[ld_addr / 4] = ld_data;
      ex_v = (q.size() > 0) && (q[0].rem == 0);
      if (ex_v) begin
        ex_a = q[0].addr; ex_d = q[0].data; ex_f = q[0].fault;
      end
    end
  end

  // Outputs are meaningful every cycle (reset zeros, then hold-last).
  always @(negedge clk) begin
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ex_v});
    chk("rsp_addr", rsp_addr, ex_a);
    chk("rsp_data", rsp_data, ex_d);
    chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, ex_f});
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] flt_addrs [3];

  initial begin
    flt_addrs[0] = 32'h0000_0006;
    flt_addrs[1] = DEPTH * 4;
    flt_addrs[2] = 32'hFFFF_FFFC;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; stall = 1'b0; flush = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) step();
    chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_addr", rsp_addr, 32'd0);
    chk("reset_data", rsp_data, 32'd0);
    chk("reset_fault", {31'd0, rsp_fault}, 32'd0);
    rst = 1'b1;

    // preload word[i] = 0x1000_0000 + i
    for (int i = 0; i < DEPTH; i++) begin
      ld_en = 1'b1; ld_addr = i * 4; ld_data = 32'h1000_0000 + i;
      step();
    end
    ld_en = 1'b0;
    step();

    // back-to-back fetch
    req_valid = 1'b1; req_addr = 32'h0; step();
    req_addr = 32'h4; step();
    chk("b2b0_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b0_data", rsp_data, 32'h1000_0000);
    chk("b2b0_addr", rsp_addr, 32'h0);
    req_addr = 32'h8; step();
    chk("b2b1_data", rsp_data, 32'h1000_0001);
    chk("b2b1_addr", rsp_addr, 32'h4);
    req_valid = 1'b0; step();
    chk("b2b2_data", rsp_data, 32'h1000_0002);
    chk("b2b2_addr", rsp_addr, 32'h8);
    step();
    chk("b2b_idle_valid", {31'd0, rsp_valid}, 32'd0);
    chk("b2b_hold_addr", rsp_addr, 32'h8);

    // stall with two in flight
    req_valid = 1'b1; req_addr = 32'hC; step();
    req_addr = 32'h10; step();
    req_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_addr", rsp_addr, 32'hC);
      chk("stall_data", rsp_data, 32'h1000_0003);
    end
    stall = 1'b0; step();
    chk("stall_next_addr", rsp_addr, 32'h10);
    chk("stall_next_data", rsp_data, 32'h1000_0004);
    step();
    chk("stall_drain_valid", {31'd0, rsp_valid}, 32'd0);

    // flush with redirect, then again with stall held during the flush
    for (int s = 0; s < 2; s++) begin
      req_valid = 1'b1; req_addr = 32'h10; step();
      flush = 1'b1; stall = (s == 1); req_addr = 32'h40; step();
      chk("flush_drop_valid", {31'd0, rsp_valid}, 32'd0);
      flush = 1'b0; stall = 1'b0; req_valid = 1'b0; step();
      chk("flush_redir_valid", {31'd0, rsp_valid}, 32'd1);
      chk("flush_redir_addr", rsp_addr, 32'h40);
      chk("flush_redir_data", rsp_data, 32'h1000_0010);
      step();
    end

    // faulting fetches
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = flt_addrs[i]; step();
      req_valid = 1'b0; step();
      chk("fault_flag", {31'd0, rsp_fault}, 32'd1);
      chk("fault_data", rsp_data, 32'd0);
      chk("fault_addr", rsp_addr, flt_addrs[i]);
    end

    // load port: read-before-write, then misaligned load ignored
    req_valid = 1'b1; req_addr = 32'h20;
    ld_en = 1'b1; ld_addr = 32'h20; ld_data = 32'hDEAD_BEEF; step();
    ld_en = 1'b0; step();
    chk("rbw_old", rsp_data, 32'h1000_0008);
    req_valid = 1'b0; step();
    chk("rbw_new", rsp_data, 32'hDEAD_BEEF);
    ld_en = 1'b1; ld_addr = 32'h22; ld_data = 32'h1234_5678; step();
    ld_en = 1'b0; req_valid = 1'b1; req_addr = 32'h20; step();
    req_valid = 1'b0; step();
    chk("ld_misalign_ignored", rsp_data, 32'hDEAD_BEEF);

    // mixed traffic checked by the model only
    for (int i = 0; i < 24; i++) begin
      req_valid = (i % 4 != 3);
      req_addr  = (i * 12) % 32'h120;
      stall     = (i % 7 == 2);
      flush     = (i % 9 == 5);
      step();
    end
    req_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (3) step();

    // async reset mid-stream; load during reset must not land
    req_valid = 1'b1; req_addr = 32'h30; step();
    req_addr = 32'h34; step();
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_addr", rsp_addr, 32'd0);
    chk("arst_data", rsp_data, 32'd0);
    chk("arst_fault", {31'd0, rsp_fault}, 32'd0);
    req_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 32'h8; ld_data = 32'hBAD0_BAD0;
    repeat (2) step();
    ld_en = 1'b0; rst = 1'b1;
    step();
    chk("post_rst_idle", {31'd0, rsp_valid}, 32'd0);
    req_valid = 1'b1; req_addr = 32'h8; step();
    req_valid = 1'b0; step();
    chk("post_rst_valid", {31'd0, rsp_valid}, 32'd1);
    chk("post_rst_addr", rsp_addr, 32'h8);
    chk("post_rst_data", rsp_data, 32'h1000_0002);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
